// File: rtl/madder_sched.sv
// Residual-add sequencer: streams C = A + B one TILE-wide beat at a time from two
// source buffers into a destination buffer, with credit-limited reads and an output FIFO.
module madder_sched #(
    parameter int ROWS     = 128,
    parameter int COLS     = 768,
    parameter int TILE     = 64,
    parameter int WIDTH    = 8,
    parameter int RD_LAT   = 2,
    parameter int SATURATE = 0,
    parameter int ADDR_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       src1_base,
    input  logic [ADDR_W-1:0]       src2_base,
    input  logic [ADDR_W-1:0]       dst_base,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr1,
    output logic [ADDR_W-1:0]       rd_addr2,
    input  logic [TILE*WIDTH-1:0]   rd_data1,
    input  logic [TILE*WIDTH-1:0]   rd_data2,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [TILE*WIDTH-1:0]   wr_data,
    input  logic                    wr_ready,
    output logic [1:0]              dbg_state
);

    localparam int BEATS      = ROWS * COLS / TILE;
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int DW         = TILE * WIDTH;
    localparam int IDX_W      = $clog2(BEATS + 1);
    localparam int CRD_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic [CRD_W-1:0]  credit;
    logic [RD_LAT-1:0] vpipe;
    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CRD_W-1:0]  fcount;
    logic [DW-1:0]     sum_beat;
    logic              push, wr_acc;

    // Write port is valid/ready: a beat transfers on wr_en && wr_ready; wr_en never
    // depends on wr_ready, and the head (wr_addr/wr_data) holds while stalled.
    assign wr_en     = (fcount != '0);
    assign wr_acc    = wr_en && wr_ready;
    assign wr_data   = fifo_mem[rptr];
    assign wr_addr   = dst_q + ADDR_W'(wr_idx);
    assign rd_addr1  = src1_q + ADDR_W'(rd_idx);
    assign rd_addr2  = src2_q + ADDR_W'(rd_idx);
    assign push      = vpipe[RD_LAT-1];
    assign dbg_state = state;

    function automatic logic [WIDTH-1:0] lane_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic signed [WIDTH:0] s;
        s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        // Overflow shows as disagreement between the two top bits of the wide sum.
        if (SATURATE != 0 && (s[WIDTH] != s[WIDTH-1]))
            lane_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            lane_add = s[WIDTH-1:0];
    endfunction

    always_comb begin
        sum_beat = '0;
        for (int k = 0; k < TILE; k++)
            sum_beat[k*WIDTH +: WIDTH] = lane_add(rd_data1[k*WIDTH +: WIDTH],
                                                  rd_data2[k*WIDTH +: WIDTH]);
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = (credit < CRD_W'(FIFO_DEPTH));
                if (rd_en && rd_idx == IDX_W'(BEATS - 1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (wr_acc && wr_idx == IDX_W'(BEATS - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            rd_idx <= '0;
            wr_idx <= '0;
            credit <= '0;
        end else if (state == S_IDLE && start) begin
            src1_q <= src1_base;
            src2_q <= src2_base;
            dst_q  <= dst_base;
            rd_idx <= '0;
            wr_idx <= '0;
            credit <= '0;
        end else begin
            if (rd_en)  rd_idx <= rd_idx + 1'b1;
            if (wr_acc) wr_idx <= wr_idx + 1'b1;
            case ({rd_en, wr_acc})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // One valid bit per issued read; its head marks the cycle read data is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wptr   <= '0;
            rptr   <= '0;
            fcount <= '0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= sum_beat;
                wptr <= (wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (wr_acc)
                rptr <= (rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
            case ({push, wr_acc})
                2'b10:   fcount <= fcount + 1'b1;
                2'b01:   fcount <= fcount - 1'b1;
                default: fcount <= fcount;
            endcase
        end
    end

endmodule

// File: doc/madder_sched.md
# madder_sched

Sequencer for the residual-add stage. It streams a ROWS x COLS signed matrix add, C = A + B, out of two source activation buffers and into a destination buffer, one TILE-element beat at a time. The element-wise adder is internal, with lane width WIDTH, and absorbs fixed-latency buffer reads. A credit-counted output FIFO handles write backpressure. It sits between the layer controller (start/done) and the activation SRAMs.

## Interface
- ROWS, 128, matrix rows
- COLS, 768, matrix columns; must be a multiple of TILE
- TILE, 64, elements per beat
- WIDTH, 8, signed element width (addends and sum)
- RD_LAT, 2, SRAM read latency in cycles (≥1)
- SATURATE, 0, 0 = two's-complement wrap, 1 = clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
- ADDR_W, 16, buffer address width
- Derived: BEATS = ROWS*COLS/TILE (1536 at defaults); FIFO_DEPTH = RD_LAT+2

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- src1_base, src2_base, dst_base  in  ADDR_W  base beat addresses, latched on accepted start
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse
- rd_en  out  1  read strobe to both source buffers
- rd_addr1, rd_addr2  out  ADDR_W  base + beat index, modulo 2^ADDR_W
- rd_data1, rd_data2  in  TILE*WIDTH  valid exactly RD_LAT cycles after rd_en; element k at [k*WIDTH +: WIDTH]
- wr_en  out  1  FIFO head valid
- wr_addr  out  ADDR_W  dst_base + beat index of head
- wr_data  out  TILE*WIDTH  sum beat at head
- wr_ready  in  1  destination accepts when wr_en && wr_ready

## Operation
- FSM states and transitions:
  - IDLE: start → RUN. Latch the bases; clear rd_idx, wr_idx and credit.
  - RUN: rd_en = (credit < FIFO_DEPTH). After beat BEATS-1 is issued → DRAIN.
  - DRAIN: no reads. After the write of beat BEATS-1 is accepted → DONE.
  - DONE: done = 1 for one cycle → IDLE.
- start outside IDLE is ignored; bases are not re-latched.
- Credit counter:
  - +1 on rd_en; -1 on an accepted write; both in the same cycle → unchanged.
  - Never exceeds FIFO_DEPTH, so the FIFO never overflows and read data is never dropped.
- Pipeline:
  - A valid shift register of length RD_LAT tracks each issued read.
  - When it emerges, the TILE lane sums are computed and pushed into the FIFO in that cycle.
- Arithmetic: lane k sum = a_k + b_k on signed WIDTH-bit operands.
  - Full WIDTH+1 result, then wrapped to WIDTH bits (SATURATE = 0) or clamped (SATURATE = 1).
- FIFO empty: wr_en = 0, wr_data don't-care. While wr_en = 1 and wr_ready = 0, wr_addr/wr_data hold stable.
- Writes leave in beat order; wr_addr increments by 1 per accepted write.
- Reset (asserted at any time, including mid-run): FSM → IDLE, all counters/FIFO/valid pipe cleared. In-flight reads are discarded.
- Reset values: busy = 0, done = 0, rd_en = 0, wr_en = 0, rd_addr1 = rd_addr2 = wr_addr = 0, wr_data = 0.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: state RUN, first rd_en with rd_addr = base.
- Beat issued at cycle t:
  - Pushed into the FIFO at t+RD_LAT.
  - Earliest wr_en at t+RD_LAT+1.
- With wr_ready held high, reads issue back-to-back (FIFO_DEPTH = RD_LAT+2 is the minimum for full throughput).
  - Last rd_en at cycle BEATS.
  - Last write at BEATS+RD_LAT+1.
  - done at BEATS+RD_LAT+2, which is 1540 at defaults; busy is high during cycles 1..1539.
- Back-to-back jobs: a start on the cycle after done is accepted.
- wr_ready low for N cycles: reads stall once credit hits FIFO_DEPTH; done is delayed by exactly N cycles.

## Test plan
- Defaults, wr_ready = 1, bases 0x0000/0x1000/0x2000, random data:
  - done exactly at cycle 1540.
  - 1536 writes to 0x2000..0x25FF in order, each beat equal to the wrapped lane sums from a reference model.
- Boundary lanes, SATURATE = 0: 0x7F+0x01 → 0x80; 0x80+0xFF → 0x7F; 0xFF+0x01 → 0x00. Same run with SATURATE = 1 → 0x7F, 0x80, 0x00.
- Random wr_ready (50%, plus 20-cycle low bursts):
  - Credit is never above 4 and the FIFO never overflows.
  - Data and address order are identical to the first test.
  - wr_data is stable while stalled.
- start pulsed at cycles 5 and 700 with different bases: the second start is ignored and all addresses use the cycle-0 bases. A start on the done+1 cycle starts a clean second job.
- rst_n low at cycle 800 for 3 cycles:
  - Outputs go to their reset values immediately (asynchronously).
  - After release, a new start runs a full job whose writes start at the new dst_base, with no stale beats from the aborted job.
- dst_base = 0xFFFF: wr_addr wraps 0xFFFF → 0x0000 → … → 0x05FE.
